// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arithmetic, bit-serial shifts,
// valid/ready handshakes on both the request and the result side.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for a request; in_ready=1
// S_SHIFT | shifting shreg one bit per cycle until cnt runs out
// S_DONE  | result/zero/overflow held; out_valid=1 until out_ready
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctr,
  input  logic             shift,
  input  logic [4:0]       shamt,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_ADDU = 4'b1001;
  localparam logic [3:0] OP_SUBU = 4'b1010;
  localparam logic [3:0] OP_LUI  = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_XOR  = 4'b1101;
  localparam logic [3:0] OP_SRA  = 4'b1110;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} sh_kind_t;

  state_t           state_q, state_d;
  sh_kind_t         sh_kind_q;
  logic [WIDTH-1:0] shreg_q;
  logic [4:0]       cnt_q;

  logic             is_shift;
  logic [4:0]       amount;
  logic [WIDTH-1:0] sum, diff, alu_res, sh_next;
  logic             add_ovf, sub_ovf, alu_ovf;
  sh_kind_t         sh_kind_in;

  assign is_shift = (alu_ctr == OP_SLL) || (alu_ctr == OP_SRL) || (alu_ctr == OP_SRA);
  assign amount   = shift ? shamt : src_a[4:0];
  assign sum      = src_a + src_b;
  assign diff     = src_a - src_b;
  // Signed overflow: result sign disagrees with what the operand signs imply.
  assign add_ovf  = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1]  != src_a[WIDTH-1]);
  assign sub_ovf  = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_ctr)
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_ADD:  begin alu_res = sum;  alu_ovf = add_ovf; end
      OP_SUB:  begin alu_res = diff; alu_ovf = sub_ovf; end
      OP_ADDU: alu_res = sum;
      OP_SUBU: alu_res = diff;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
      OP_LUI:  alu_res = src_b << 16;
      OP_NOR:  alu_res = ~(src_a | src_b);
      OP_XOR:  alu_res = src_a ^ src_b;
      default: begin alu_res = '0; alu_ovf = 1'b0; end
    endcase
  end

  always_comb begin
    sh_kind_in = SH_LL;
    case (alu_ctr)
      OP_SRL:  sh_kind_in = SH_RL;
      OP_SRA:  sh_kind_in = SH_RA;
      default: sh_kind_in = SH_LL;
    endcase
  end

  always_comb begin
    sh_next = shreg_q;
    case (sh_kind_q)
      SH_LL:   sh_next = {shreg_q[WIDTH-2:0], 1'b0};
      SH_RL:   sh_next = {1'b0, shreg_q[WIDTH-1:1]};
      SH_RA:   sh_next = {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
      default: sh_next = shreg_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (is_shift && (amount != 5'd0)) state_d = S_SHIFT;
          else                              state_d = S_DONE;
        end
      end
      S_SHIFT: if (cnt_q <= 5'd1) state_d = S_DONE;
      S_DONE:  if (out_ready)     state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      shreg_q   <= '0;
      cnt_q     <= 5'd0;
      sh_kind_q <= SH_LL;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (is_shift) begin
              shreg_q   <= src_b;
              cnt_q     <= amount;
              sh_kind_q <= sh_kind_in;
              overflow  <= 1'b0;
              if (amount == 5'd0) begin
                result <= src_b;
                zero   <= (src_b == '0);
              end
            end else begin
              result   <= alu_res;
              zero     <= (alu_res == '0);
              overflow <= alu_ovf;
            end
          end
        end
        S_SHIFT: begin
          shreg_q <= sh_next;
          cnt_q   <= cnt_q - 5'd1;
          // Final step: publish the shifted value directly, no extra cycle.
          if (cnt_q <= 5'd1) begin
            result <= sh_next;
            zero   <= (sh_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector table through a scoreboard
// queue, plus hand sequences for backpressure and reset mid-shift.
module tb_alu_exec_unit;

  logic        Clk = 1'b0;
  logic        reset, in_valid, in_ready, shift, out_valid, out_ready, zero, overflow;
  logic [3:0]  alu_ctr;
  logic [4:0]  shamt;
  logic [31:0] src_a, src_b, result;

  always #5 Clk = ~Clk;

  alu_exec_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctr(alu_ctr), .shift(shift), .shamt(shamt), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .overflow(overflow)
  );

  typedef struct {
    logic [3:0]  ctr;
    logic        sh;
    logic [4:0]  amt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ovf;
  } exp_t;

  localparam int NV = 23;
  vec_t vecs[NV];
  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(logic [3:0] c, logic s, logic [4:0] n, logic [31:0] a,
                              logic [31:0] b, logic [31:0] r, logic o, int l);
    vec_t v;
    v.ctr = c; v.sh = s; v.amt = n; v.a = a; v.b = b; v.res = r; v.ovf = o; v.lat = l;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic compare_head(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, " sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({tag, " result"},   result,   e.res);
      check({tag, " zero"},     {31'd0, zero},     {31'd0, e.zero});
      check({tag, " overflow"}, {31'd0, overflow}, {31'd0, e.ovf});
    end
  endtask

  task automatic run_op(input vec_t v, input string tag);
    exp_t e;
    int   lat;
    logic busy_ok;
    in_valid = 1'b1; alu_ctr = v.ctr; shift = v.sh; shamt = v.amt; src_a = v.a; src_b = v.b;
    check({tag, " in_ready_idle"}, {31'd0, in_ready}, 32'd1);
    @(posedge Clk); #1;
    // Scramble inputs after acceptance; the unit must ignore them.
    in_valid = 1'b0;
    alu_ctr = 4'($urandom); shift = 1'($urandom); shamt = 5'($urandom);
    src_a = $urandom; src_b = $urandom;
    e.res = v.res; e.zero = (v.res == 32'd0); e.ovf = v.ovf;
    sb_q.push_back(e);
    lat = 1; busy_ok = 1'b1;
    while (!out_valid && lat <= 40) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      out_ready = 1'($urandom);
      @(posedge Clk); #1;
      lat++;
    end
    out_ready = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(v.lat));
    check({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
    if (out_valid) compare_head(tag);
    else void'(sb_q.pop_front());
    out_ready = 1'b1;
    @(posedge Clk); #1;
    out_ready = 1'b0;
    check({tag, " out_valid_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    vecs[0]  = mk(4'b0010, 0, 0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1, 1);
    vecs[1]  = mk(4'b1001, 0, 0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1);
    vecs[2]  = mk(4'b0111, 0, 0, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 1);
    vecs[3]  = mk(4'b1000, 0, 0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0, 1);
    vecs[4]  = mk(4'b0110, 0, 0, 32'h00000005, 32'h00000005, 32'h00000000, 0, 1);
    vecs[5]  = mk(4'b0110, 0, 0, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1, 1);
    vecs[6]  = mk(4'b0000, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 1);
    vecs[7]  = mk(4'b0001, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 1);
    vecs[8]  = mk(4'b1100, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 0, 1);
    vecs[9]  = mk(4'b1101, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 1);
    vecs[10] = mk(4'b1011, 0, 0, 32'h12345678, 32'h0000ABCD, 32'hABCD0000, 0, 1);
    vecs[11] = mk(4'b1010, 0, 0, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 0, 1);
    vecs[12] = mk(4'b0101, 0, 0, 32'h00000005, 32'h00000007, 32'h00000000, 0, 1);
    vecs[13] = mk(4'b1111, 0, 0, 32'h7FFFFFFF, 32'h00000001, 32'h00000000, 0, 1);
    vecs[14] = mk(4'b1110, 0, 0, 32'h00000004, 32'hF0000000, 32'hFF000000, 0, 5);
    vecs[15] = mk(4'b1110, 1, 31, 32'h00000000, 32'h80000000, 32'hFFFFFFFF, 0, 32);
    vecs[16] = mk(4'b0100, 1, 31, 32'h00000000, 32'h80000000, 32'h00000001, 0, 32);
    vecs[17] = mk(4'b0011, 1, 4, 32'h7FFFFFFF, 32'h00001234, 32'h00012340, 0, 5);
    vecs[18] = mk(4'b0011, 1, 0, 32'h0000001F, 32'h00001234, 32'h00001234, 0, 1);
    vecs[19] = mk(4'b0011, 1, 1, 32'h00000000, 32'h80000000, 32'h00000000, 0, 2);
    vecs[20] = mk(4'b0100, 0, 0, 32'hFFFFFFE3, 32'hF0000000, 32'h1E000000, 0, 4);
    vecs[21] = mk(4'b0010, 0, 0, 32'h00000001, 32'h00000002, 32'h00000003, 0, 1);
    vecs[22] = mk(4'b0010, 0, 0, 32'h80000000, 32'h80000000, 32'h00000000, 1, 1);

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; alu_ctr = 4'd0; shift = 1'b0;
    shamt = 5'd0; src_a = 32'd0; src_b = 32'd0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst in_ready",  {31'd0, in_ready},  32'd1);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst result",    result,             32'd0);
    check("rst zero",      {31'd0, zero},      32'd0);
    check("rst overflow",  {31'd0, overflow},  32'd0);
    reset = 1'b0;
    @(posedge Clk); #1;

    for (int i = 0; i < NV; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Zero-amount shift held under backpressure; a competing request is ignored.
    in_valid = 1'b1; alu_ctr = 4'b0011; shift = 1'b1; shamt = 5'd0;
    src_a = 32'hFFFFFFFF; src_b = 32'h00001234; out_ready = 1'b0;
    @(posedge Clk); #1;
    e.res = 32'h00001234; e.zero = 1'b0; e.ovf = 1'b0;
    sb_q.push_back(e);
    alu_ctr = 4'b0000; src_b = 32'h0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp%0d out_valid", k), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp%0d in_ready", k),  {31'd0, in_ready},  32'd0);
      check($sformatf("bp%0d result", k),    result, 32'h00001234);
      @(posedge Clk); #1;
    end
    in_valid = 1'b0;
    compare_head("bp");
    out_ready = 1'b1;
    @(posedge Clk); #1;
    out_ready = 1'b0;
    check("bp in_ready_back", {31'd0, in_ready},  32'd1);
    check("bp out_valid_off", {31'd0, out_valid}, 32'd0);

    // Reset during a long srl must discard the pending result.
    in_valid = 1'b1; alu_ctr = 4'b0100; shift = 1'b1; shamt = 5'd20; src_b = 32'hFFFF0000;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge Clk);
    #1;
    check("mid in_ready_busy", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    @(posedge Clk); #1;
    reset = 1'b0;
    check("mid out_valid", {31'd0, out_valid}, 32'd0);
    check("mid in_ready",  {31'd0, in_ready},  32'd1);
    check("mid result",    result,             32'd0);
    check("mid overflow",  {31'd0, overflow},  32'd0);
    repeat (20) @(posedge Clk);
    #1;
    check("mid no_late_valid", {31'd0, out_valid}, 32'd0);
    run_op(mk(4'b1011, 0, 0, 32'h0, 32'h000000AB, 32'h00AB0000, 0, 1), "lui_after_rst");

    check("sb drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
